avalon_mem_responder: RTL and testbench

//  Avalon-MM memory responder (slave) at the far end of the CPU's read/write/waitrequest data/instruction bus.

---
 rtl/avalon_mem_responder.sv | 121 ++++++++++++
 tb/tb_avalon_mem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: Avalon-MM RAM responder with programmable waitrequest stalls and sticky protocol error flag
module avalon_mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, rdata_q, rdata_d;
  logic [3:0] be_q, be_d;
  logic rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic req, changed, bad, c_rd, c_wr, enter_ack;
  logic [31:0] c_addr, off;
  logic [AW-1:0] word;
  logic [31:0] mem [DEPTH];

  assign req = read | write;
  assign waitrequest = req & (state_q != ACK);
  assign readdata = rdata_q;
  assign err = err_q;

  // Decode the access being served: live inputs in IDLE, latched request afterwards
  always_comb begin
    c_addr = state_q == IDLE ? address : addr_q;
    c_rd = state_q == IDLE ? read : rd_q;
    c_wr = state_q == IDLE ? write : wr_q;
    off = c_addr - BASE_ADDR;
    word = off[AW+1:2];
    bad = (c_rd & c_wr) | (c_addr[1:0] != 2'b00) | (off >= 32'(4 * DEPTH));
    changed = req & ((address != addr_q) | (read != rd_q) | (write != wr_q) |
              (wr_q & ((byteenable != be_q) | (writedata != wd_q))));
  end

  // Next-state, request latch, read data and error flag
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    rd_d = rd_q;
    wr_d = wr_q;
    be_d = be_q;
    wd_d = wd_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d = address;
        rd_d = read;
        wr_d = write;
        be_d = byteenable;
        wd_d = writedata;
        state_d = WAIT_CYCLES == 1 ? ACK : WAIT;
        cnt_d = 8'(WAIT_CYCLES - 2);
      end
      WAIT: if (!req) begin
        state_d = IDLE;
        err_d = 1'b1;
      end else begin
        err_d = err_q | changed;
        state_d = cnt_q == 8'd0 ? ACK : WAIT;
        cnt_d = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
      end
      ACK: begin
        state_d = IDLE;
        err_d = err_q | changed;
      end
      default: state_d = IDLE;
    endcase
    enter_ack = (state_d == ACK) && (state_q != ACK);
    if (enter_ack) begin
      rdata_d = bad ? 32'd0 : c_rd ? mem[word] : rdata_q;
      err_d = err_d | bad;
    end
  end

  // State and latch registers, cleared asynchronously so a pending write is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      be_q <= '0;
      wd_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      be_q <= be_d;
      wd_q <= wd_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end

  // RAM byte-lane write on the edge leaving ACK
  always_ff @(posedge clk) begin
    if (state_q == ACK && wr_q && !bad)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[word][8*i +: 8] <= wd_q[8*i +: 8];
  end
endmodule

// File: tb/tb_avalon_mem_responder.sv
// tb_avalon_mem_responder: table-driven and scoreboard checks of the Avalon-MM RAM responder
module tb_avalon_mem_responder;
  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int DEPTH = 1024;
  localparam int WC = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] address = '0;
  logic read = 1'b0;
  logic write = 1'b0;
  logic [3:0] byteenable = '0;
  logic [31:0] writedata = '0;
  logic waitrequest, err;
  logic [31:0] readdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic r;
    logic w;
    logic [31:0] a;
    logic [3:0] be;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  avalon_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WC), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // mode 0 normal, 1 drop request in WAIT, 2 alter writedata in WAIT, 3 reset in WAIT
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input int mode, input string tag);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    read = r;
    write = w;
    address = a;
    byteenable = b;
    writedata = d;
    #1 lat = 1;
    while (waitrequest && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2 && mode == 1) begin
        read = 1'b0;
        write = 1'b0;
        @(negedge clk);
        return;
      end
      if (lat == 2 && mode == 2) writedata = ~d;
      if (lat == 2 && mode == 3) begin
        reset_n = 1'b0;
        #1 check({tag, " wreq in reset"}, {31'd0, waitrequest}, 32'd1);
        check({tag, " rdata in reset"}, readdata, 32'd0);
        check({tag, " err in reset"}, {31'd0, err}, 32'd0);
        read = 1'b0;
        write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
    end
    check({tag, " latency"}, lat, WC + 1);
    if (r) begin
      e = exp_q.pop_front();
      check({tag, " readdata"}, readdata, e);
    end
    read = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    tbl[0]  = '{1'b0, 1'b1, BASE + 32'd8,     4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, BASE + 32'd8,     4'hF, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, BASE + 32'd8,     4'h5, 32'h11223344, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, BASE + 32'd8,     4'hF, 32'h0,        32'hDE22BE44};
    tbl[4]  = '{1'b0, 1'b1, BASE,             4'hF, 32'hA5A5A5A5, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, BASE,             4'h3, 32'h12345678, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, BASE,             4'hF, 32'h0,        32'hA5A55678};
    tbl[7]  = '{1'b0, 1'b1, BASE + 32'hFFC,   4'hF, 32'h0BADF00D, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, BASE + 32'hFFC,   4'hF, 32'h0,        32'h0BADF00D};
    tbl[9]  = '{1'b0, 1'b1, BASE + 32'd4,     4'hF, 32'h00000000, 32'h0};
    tbl[10] = '{1'b0, 1'b1, BASE + 32'd4,     4'hA, 32'hAABBCCDD, 32'h0};
    tbl[11] = '{1'b1, 1'b0, BASE + 32'd4,     4'hF, 32'h0,        32'hAA00CC00};
    read = 1'b1;
    address = BASE + 32'd8;
    repeat (2) @(negedge clk);
    check("reset wreq", {31'd0, waitrequest}, 32'd1);
    check("reset rdata", readdata, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    #1 lat = 1;
    while (waitrequest && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("post-reset latency", lat, WC + 1);
    read = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].r) exp_q.push_back(tbl[i].exp);
      access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].d, 0, $sformatf("vec%0d", i));
    end
    check("table err", {31'd0, err}, 32'd0);
    exp_q.push_back(32'd0);
    access(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 4'hF, 32'h0, 0, "range rd");
    check("range err", {31'd0, err}, 32'd1);
    pulse_reset();
    check("err cleared", {31'd0, err}, 32'd0);
    access(1'b0, 1'b1, BASE + 32'd2, 4'hF, 32'h55555555, 0, "misalign wr");
    check("misalign err", {31'd0, err}, 32'd1);
    exp_q.push_back(32'hA5A55678);
    access(1'b1, 1'b0, BASE, 4'hF, 32'h0, 0, "misalign keep");
    pulse_reset();
    exp_q.push_back(32'hDE22BE44);
    access(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, 0, "pre rw rd");
    exp_q.push_back(32'd0);
    access(1'b1, 1'b1, BASE + 32'd8, 4'hF, 32'h99999999, 0, "rw");
    check("rw err", {31'd0, err}, 32'd1);
    pulse_reset();
    access(1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'h0, 1, "drop");
    check("drop err", {31'd0, err}, 32'd1);
    exp_q.push_back(32'hDE22BE44);
    access(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, 0, "drop keep");
    pulse_reset();
    access(1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'h77777777, 2, "chg wd");
    check("chg err", {31'd0, err}, 32'd1);
    exp_q.push_back(32'h77777777);
    access(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, 0, "chg latched");
    pulse_reset();
    access(1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'h0, 3, "rst mid");
    exp_q.push_back(32'h77777777);
    access(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, 0, "rst keep");
    check("rst err", {31'd0, err}, 32'd0);
    check("queue empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
